// File: rtl/program_sequencer.sv
// Fetch stage of the 8-bit core: drives the program-memory address, classifies the
// fetched word, resolves page-relative jumps in the fetch cycle and detects jump-to-self halt.
module program_sequencer #(
  parameter int PC_W  = 8,
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_sync_reset,
  input  logic [7:0]       i_pm_data,
  input  logic             i_z_flag,
  input  logic             i_hold,
  output logic [PC_W-1:0]  o_pm_addr,
  output logic [PC_W-1:0]  o_pc,
  output logic [7:0]       o_ir,
  output logic [2:0]       o_instr_class,
  output logic             o_instr_valid,
  output logic             o_jump_taken,
  output logic             o_halted,
  output logic [CNT_W-1:0] o_instr_count,
  output logic [1:0]       o_dbg_state
);

  localparam logic [1:0] S_RESET = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_HALT  = 2'd2;

  localparam logic [2:0] C_RESET            = 3'd0;
  localparam logic [2:0] C_LOAD             = 3'd1;
  localparam logic [2:0] C_MOVE             = 3'd2;
  localparam logic [2:0] C_ALU              = 3'd3;
  localparam logic [2:0] C_JUMP             = 3'd4;
  localparam logic [2:0] C_CONDITIONAL_JUMP = 3'd5;
  localparam logic [2:0] C_JUMP_NEXT        = 3'd6;

  logic [1:0]       r_state;
  logic [PC_W-1:0]  r_pc;
  logic [CNT_W-1:0] r_count;

  logic             w_run;
  logic [7:0]       w_ir;
  logic [2:0]       w_class;
  logic [PC_W-1:0]  w_target;
  logic [PC_W-1:0]  w_pc_inc;
  logic [PC_W-1:0]  w_next_pc;
  logic             w_branch;
  logic             w_retire;
  logic             w_halt_hit;
  logic             w_count_max;

  assign w_run       = (r_state == S_RUN);
  assign w_ir        = w_run ? i_pm_data : 8'h00;
  assign w_target    = {r_pc[PC_W-1:4], w_ir[3:0]};
  assign w_pc_inc    = r_pc + {{(PC_W-1){1'b0}}, 1'b1};
  assign w_retire    = w_run & ~i_hold;
  assign w_count_max = &r_count;

  // z_flag only matters for the 1111xxxx group; everything else is pure decode.
  always_comb begin
    w_class = C_RESET;
    if (w_run) begin
      casez (w_ir)
        8'b0???????: w_class = C_LOAD;
        8'b10??????: w_class = C_MOVE;
        8'b110?????: w_class = C_ALU;
        8'b1110????: w_class = C_JUMP;
        default:     w_class = i_z_flag ? C_JUMP_NEXT : C_CONDITIONAL_JUMP;
      endcase
    end
  end

  assign w_branch   = (w_class == C_JUMP) | (w_class == C_CONDITIONAL_JUMP);
  assign w_halt_hit = w_retire & (w_class == C_JUMP) & (w_target == r_pc);

  // A held instruction re-presents the same address so memory returns the same word.
  always_comb begin
    w_next_pc = '0;
    case (r_state)
      S_RUN: begin
        if (i_hold)        w_next_pc = r_pc;
        else if (w_branch) w_next_pc = w_target;
        else               w_next_pc = w_pc_inc;
      end
      S_HALT:  w_next_pc = r_pc;
      default: w_next_pc = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_sync_reset) begin
      r_state <= S_RESET;
      r_pc    <= '0;
      r_count <= '0;
    end else begin
      case (r_state)
        S_RESET: begin
          r_state <= S_RUN;
          r_pc    <= w_next_pc;
        end
        S_RUN: begin
          r_pc <= w_next_pc;
          if (w_retire && !w_count_max)
            r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
          if (w_halt_hit)
            r_state <= S_HALT;
        end
        S_HALT: begin
          r_state <= S_HALT;
        end
        default: begin
          r_state <= S_RESET;
          r_pc    <= '0;
        end
      endcase
    end
  end

  assign o_pm_addr     = w_next_pc;
  assign o_pc          = r_pc;
  assign o_ir          = w_ir;
  assign o_instr_class = w_class;
  assign o_instr_valid = w_run;
  assign o_jump_taken  = w_retire & w_branch;
  assign o_halted      = (r_state == S_HALT);
  assign o_instr_count = r_count;
  assign o_dbg_state   = r_state;

endmodule
